// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and helpers for the LC-3 memory arbiter
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

    typedef enum logic {
        MEM_RD,
        MEM_WR
    } mem_op_e;

    // Channel index width; a single channel still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lc3_rr_arbiter.sv
// rtl/lc3_rr_arbiter.sv - combinational round-robin pick starting after ptr
module lc3_rr_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int NUM_CH = 2,
    localparam int IDX_W = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any
);

    function automatic int wrap(input int i);
        return (i >= NUM_CH) ? i - NUM_CH : i;
    endfunction

    // Search ptr+1 .. ptr+NUM_CH so the last winner has the lowest priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!any && req[wrap(int'(ptr) + k)]) begin
                any                         = 1'b1;
                grant[wrap(int'(ptr) + k)]  = 1'b1;
                grant_idx                   = IDX_W'(wrap(int'(ptr) + k));
            end
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - N-channel round-robin arbiter onto one fixed-latency memory port
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_rdy
);

    localparam int IDX_W = idx_width(NUM_CH);
    localparam int CNT_W = (MEM_LAT >= 1) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_LAT);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("lc3_mem_arbiter: NUM_CH must be >= 1");
    end
    if (MEM_LAT < 1) begin : g_bad_mem_lat
        $error("lc3_mem_arbiter: MEM_LAT must be >= 1");
    end

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  gnt_idx_q;
    mem_op_e           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [NUM_CH-1:0] arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic              wait_done;

    lc3_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign wait_done = (cnt_q == CNT_MAX) && mem_rdy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (arb_any) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT:  if (wait_done) state_d = ARB_RESP;
            ARB_RESP:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Transaction latch, latency counter and captured read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q  <= IDX_W'(NUM_CH - 1);
            gnt_idx_q <= '0;
            op_q      <= MEM_RD;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (arb_any) begin
                        gnt_idx_q <= arb_idx;
                        rr_ptr_q  <= arb_idx;
                        op_q      <= req_we[arb_idx] ? MEM_WR : MEM_RD;
                        addr_q    <= req_addr[arb_idx*ADDR_W +: ADDR_W];
                        wdata_q   <= req_wdata[arb_idx*DATA_W +: DATA_W];
                    end
                end
                ARB_ISSUE: cnt_q <= CNT_W'(1);
                ARB_WAIT: begin
                    if (wait_done) begin
                        rdata_q <= (op_q == MEM_WR) ? '0 : mem_rdata;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Grant is Mealy: visible only in the IDLE cycle the handshake completes.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            ARB_IDLE:  req_ready = arb_grant;
            ARB_ISSUE: begin
                mem_en = 1'b1;
                mem_we = (op_q == MEM_WR);
            end
            ARB_RESP:  rsp_valid[gnt_idx_q] = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb/tb_lc3_mem_arbiter.sv - directed self-checking bench for lc3_mem_arbiter
module tb_lc3_mem_arbiter;
    import lc3_mem_pkg::*;

    typedef struct {
        int          ch;
        mem_op_e     op;
        logic [15:0] data;
    } mem_txn_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [31:0] req_addr, req_wdata;
    logic [15:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_we, mem_rdy;

    logic [3:0]  req_valid4, req_ready4, req_we4, rsp_valid4;
    logic [63:0] req_addr4, req_wdata4;
    logic [15:0] rsp_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
    logic        mem_en4, mem_we4, mem_rdy4;

    int checks = 0;
    int errors = 0;

    lc3_mem_arbiter #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
    );

    lc3_mem_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut4 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_we(req_we4),
        .req_addr(req_addr4), .req_wdata(req_wdata4),
        .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .mem_rdata(mem_rdata4), .mem_rdy(mem_rdy4)
    );

    // Memory model for the 4-channel instance: data derived from the held address.
    assign mem_rdata4 = mem_addr4 ^ 16'h5A5A;
    assign mem_rdy4   = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic smp;
        @(negedge clock);
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int ptr);
        int c;
        rr_pick = -1;
        for (int k = 4; k >= 1; k--) begin
            c = (ptr + k) % 4;
            if (v[c]) rr_pick = c;
        end
    endfunction

    logic [1:0] exp_gnt;
    int         ptr4, g, accepted, responded;
    logic       busy4, drain;
    logic [3:0] acc;
    mem_txn_t   pend;

    initial begin
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mem_rdata = '0; mem_rdy = 1'b1;
        req_valid4 = '0; req_we4 = '0; req_addr4 = '0; req_wdata4 = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        smp;
        check("rst_ready", req_ready, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);

        // Single read on ch0
        cyc; req_valid = 2'b01; req_we = 2'b00; req_addr[15:0] = 16'h3000; mem_rdata = 16'hBEEF;
        smp; check("t2_ready", req_ready, 2'b01);
        cyc; req_valid = 2'b00;
        smp; check("t2_mem_en", mem_en, 1); check("t2_mem_we", mem_we, 0); check("t2_mem_addr", mem_addr, 16'h3000);
        cyc; smp; check("t2_en_once", mem_en, 0); check("t2_rsp_early", rsp_valid, 0);
        cyc; smp; check("t2_rsp_early2", rsp_valid, 0);
        cyc; smp; check("t2_rsp_valid", rsp_valid, 2'b01); check("t2_rsp_rdata", rsp_rdata, 16'hBEEF);

        // Write on ch1
        cyc; req_valid = 2'b10; req_we = 2'b10; req_addr[31:16] = 16'h4000; req_wdata[31:16] = 16'h1234;
        smp; check("t3_ready", req_ready, 2'b10);
        cyc; req_valid = 2'b00;
        smp; check("t3_mem_en", mem_en, 1); check("t3_mem_we", mem_we, 1);
        check("t3_mem_addr", mem_addr, 16'h4000); check("t3_mem_wdata", mem_wdata, 16'h1234);
        cyc; smp; check("t3_en_once", mem_en, 0); check("t3_we_once", mem_we, 0);
        cyc; cyc; smp; check("t3_rsp_valid", rsp_valid, 2'b10); check("t3_rsp_rdata", rsp_rdata, 0);
        req_we = 2'b00;

        // Contention: both channels valid throughout
        cyc; req_valid = 2'b11; req_addr = {16'h2222, 16'h1111};
        for (int k = 0; k < 4; k++) begin
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            smp; check("t4_grant", req_ready, exp_gnt);
            repeat (4) cyc;
            smp; check("t4_rsp", rsp_valid, exp_gnt);
            cyc;
        end
        req_valid = 2'b00;

        // Stall: mem_rdy low for three cycles while cnt == MEM_LAT
        cyc; req_valid = 2'b01; req_addr[15:0] = 16'h5000; mem_rdata = 16'hCAFE;
        smp; check("t5_ready", req_ready, 2'b01);
        for (int i = 1; i <= 7; i++) begin
            cyc;
            if (i == 1) req_valid = 2'b00;
            if (i == 3) mem_rdy = 1'b0;
            if (i == 6) mem_rdy = 1'b1;
            smp;
            if (i < 7) check("t5_mem_addr", mem_addr, 16'h5000);
            check("t5_rsp", rsp_valid, (i == 7) ? 2'b01 : 2'b00);
        end
        check("t5_rsp_rdata", rsp_rdata, 16'hCAFE);

        // Reset in the middle of WAIT drops the transaction
        cyc; req_valid = 2'b01; req_addr[15:0] = 16'h6000;
        smp; check("t1_ready", req_ready, 2'b01);
        cyc; req_valid = 2'b00;
        smp; check("t1_mem_en", mem_en, 1);
        cyc; smp;
        cyc; reset = 1'b1;
        smp;
        check("t1_ready_rst", req_ready, 0); check("t1_mem_en_rst", mem_en, 0);
        check("t1_mem_we_rst", mem_we, 0); check("t1_mem_addr_rst", mem_addr, 0);
        check("t1_mem_wdata_rst", mem_wdata, 0); check("t1_rsp_valid_rst", rsp_valid, 0);
        check("t1_rsp_rdata_rst", rsp_rdata, 0);
        cyc; reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc; smp;
            check("t1_no_rsp", rsp_valid, 0);
            check("t1_no_en", mem_en, 0);
        end
        cyc; req_valid = 2'b11;
        smp; check("t1_first_ch0", req_ready, 2'b01);
        cyc; req_valid = 2'b00;
        repeat (5) cyc;

        // Four channels, MEM_LAT=1, random valid/withdraw against a reference model
        ptr4 = 3; busy4 = 1'b0; drain = 1'b0; acc = '0; accepted = 0; responded = 0;
        for (int n = 0; n < 300; n++) begin
            cyc;
            if (n == 260) drain = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    req_valid4[i] = 1'b0;
                end else if (req_valid4[i]) begin
                    if ($urandom_range(7) == 0) req_valid4[i] = 1'b0;
                end else if (!drain && $urandom_range(2) == 0) begin
                    req_valid4[i]           = 1'b1;
                    req_we4[i]              = 1'($urandom_range(1));
                    req_addr4[i*16 +: 16]   = 16'($urandom);
                    req_wdata4[i*16 +: 16]  = 16'($urandom);
                end
            end
            smp;
            if (!busy4 && req_valid4 != 4'b0) begin
                g = rr_pick(req_valid4, ptr4);
                check("t6_grant", {28'b0, req_ready4}, 32'(1) << g);
                ptr4      = g;
                busy4     = 1'b1;
                pend.ch   = g;
                pend.op   = req_we4[g] ? MEM_WR : MEM_RD;
                pend.data = (pend.op == MEM_WR) ? 16'h0000 : (req_addr4[g*16 +: 16] ^ 16'h5A5A);
                accepted++;
            end else begin
                check("t6_no_grant", {28'b0, req_ready4}, 0);
            end
            acc = req_ready4 & req_valid4;
            if (rsp_valid4 != 4'b0) begin
                check("t6_rsp_when_busy", {31'b0, busy4}, 1);
                check("t6_rsp_ch", {28'b0, rsp_valid4}, 32'(1) << pend.ch);
                check("t6_rsp_data", {16'b0, rsp_rdata4}, {16'b0, pend.data});
                busy4 = 1'b0;
                responded++;
            end
        end
        check("t6_rsp_count", responded, accepted);
        check("t6_drained", {31'b0, busy4}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
